// File: rtl/aes_engine_arbiter_if.sv
// Client request/response and cipher-core handshake bundle for aes_engine_arbiter.
// slave = the arbiter, master = the clients plus the core controller.
interface aes_engine_arbiter_if #(parameter int DATA_W = 128);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [DATA_W-1:0] req0_key;
  logic              req0_dec;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [DATA_W-1:0] req1_key;
  logic              req1_dec;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              core_start;
  logic              core_dec;
  logic [DATA_W-1:0] core_data;
  logic [DATA_W-1:0] core_key;
  logic [DATA_W-1:0] core_result;
  logic              core_done;
  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req0_key, req0_dec,
    input  req1_valid, req1_data, req1_key, req1_dec,
    input  rsp0_ready, rsp1_ready, core_result, core_done,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    output core_start, core_dec, core_data, core_key, busy
  );

  modport master (
    output req0_valid, req0_data, req0_key, req0_dec,
    output req1_valid, req1_data, req1_key, req1_dec,
    output rsp0_ready, rsp1_ready, core_result, core_done,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
    input  core_start, core_dec, core_data, core_key, busy
  );
endinterface

// File: rtl/aes_engine_arbiter.sv
// Round-robin arbiter sharing one AES core between two clients, one job in flight.
// Optional core watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_engine_arbiter #(
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_engine_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              core_start_q;
  logic              core_dec_q;
  logic [DATA_W-1:0] core_data_q;
  logic [DATA_W-1:0] core_key_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic              busy_q;
  logic              sel0;
  logic              sel1;
  logic              rsp_ready_g;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  // On a tie the port that was not served last wins.
  always_comb begin
    sel0        = bus.req0_valid && (!bus.req1_valid || last_grant);
    sel1        = bus.req1_valid && (!bus.req0_valid || !last_grant);
    rsp_ready_g = grant ? bus.rsp1_ready : bus.rsp0_ready;
  end

  assign bus.req0_ready = (state == IDLE) && sel0;
  assign bus.req1_ready = (state == IDLE) && sel1;
  assign bus.core_start = core_start_q;
  assign bus.core_dec   = core_dec_q;
  assign bus.core_data  = core_data_q;
  assign bus.core_key   = core_key_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      core_start_q <= 1'b0;
      core_dec_q   <= 1'b0;
      core_data_q  <= '0;
      core_key_q   <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel0 || sel1) begin
            core_data_q  <= sel1 ? bus.req1_data : bus.req0_data;
            core_key_q   <= sel1 ? bus.req1_key  : bus.req0_key;
            core_dec_q   <= sel1 ? bus.req1_dec  : bus.req0_dec;
            grant        <= sel1;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
          wait_cnt     <= '0;
`endif
          state        <= WAIT;
        end
        // A real done always beats a watchdog expiry in the same cycle.
        WAIT: begin
          if (bus.core_done) begin
            rsp_data_q   <= bus.core_result;
            rsp_err_q    <= 1'b0;
            rsp0_valid_q <= !grant;
            rsp1_valid_q <= grant;
            state        <= RESP;
          end
`ifdef AES_ARB_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b1;
            rsp0_valid_q <= !grant;
            rsp1_valid_q <= grant;
            state        <= RESP;
          end else begin
            wait_cnt     <= wait_cnt + TW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready_g) begin
            last_grant   <= grant;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_engine_arbiter.sv
// Scoreboard bench for aes_engine_arbiter with a latency-programmable core model.
// Covers the AES_ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_aes_engine_arbiter;
  localparam int DATA_W = 128;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct packed {
    logic              port;
    logic              err;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;
  int core_lat = 5;
  bit core_auto = 1'b1;
  logic model_done = 1'b0;
  logic inj_done = 1'b0;
  logic [DATA_W-1:0] model_result = '0;

  aes_engine_arbiter_if #(.DATA_W(DATA_W)) bus();

  aes_engine_arbiter #(.DATA_W(DATA_W), .TIMEOUT(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.core_done   = model_done | inj_done;
  assign bus.core_result = model_result;

  // Stand-in cipher: real FIPS-197 vector, otherwise an arbitrary keyed mix.
  function automatic logic [DATA_W-1:0] core_fn(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] k,
                                                 input logic dec);
    if (!dec && k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    if (dec && k == FIPS_KEY && d == FIPS_CT) return FIPS_PT;
    return {d[63:0], d[127:64]} ^ k ^ {DATA_W{dec}};
  endfunction

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model: done pulses core_lat cycles after the start cycle; reset aborts the job.
  initial begin : core_model
    logic [DATA_W-1:0] res;
    bit aborted;
    forever begin
      @(negedge clk);
      if (bus.core_start && core_auto) begin
        res = core_fn(bus.core_data, bus.core_key, bus.core_dec);
        aborted = 1'b0;
        for (int i = 0; i < core_lat; i++) begin
          @(negedge clk);
          if (!reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          model_result = res;
          model_done = 1'b1;
          @(negedge clk);
          model_done = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_key = '0; bus.req0_dec = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_key = '0; bus.req1_dec = 1'b0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Presents a request and returns just after the accepting edge (cycle T0).
  task automatic accept(input bit port, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] k,
                        input logic dec, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (port) begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_key = k; bus.req1_dec = dec;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_key = k; bus.req0_dec = dec;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (port) bus.req1_valid = 1'b0;
    else      bus.req0_valid = 1'b0;
  endtask

  // Counts cycles after acceptance until either response valid is seen.
  task automatic wait_rsp(input int budget, output int cyc, output bit port, output bit ok);
    ok = 1'b0; cyc = 0; port = 1'b0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1) begin
        cyc = i; port = bus.rsp1_valid; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take_rsp(input bit port);
    if (port) bus.rsp1_ready = 1'b1;
    else      bus.rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] scal;
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    scal = {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
            bus.core_start, bus.core_dec, bus.busy, bus.rsp_err};
    tests_run++;
    if (scal !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_scalars: got %b, expected 00000000", scal); end
    tests_run++;
    if ((bus.core_data | bus.core_key | bus.rsp_data) !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_buses: got data %h key %h rsp %h, expected 0", bus.core_data, bus.core_key, bus.rsp_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_encrypt();
    bit ok;
    int start_cnt, start_cyc, rsp_cyc;
    bit saw1;
    logic [DATA_W-1:0] issue_data;
    exp_t e;
    core_lat = 40;
    accept(1'b0, FIPS_PT, FIPS_KEY, 1'b0, ok);
    sb.push_back('{port: 1'b0, err: 1'b0, data: FIPS_CT});
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL enc_accept: got %0b, expected 1", ok); end
    start_cnt = 0; start_cyc = 0; rsp_cyc = 0; saw1 = 1'b0; issue_data = '0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (c == 1) issue_data = bus.core_data;
      if (bus.core_start === 1'b1) begin start_cnt++; start_cyc = c; end
      if (bus.rsp1_valid === 1'b1) saw1 = 1'b1;
      if (bus.rsp0_valid === 1'b1) begin rsp_cyc = c; break; end
    end
    tests_run++;
    if (start_cnt != 1 || start_cyc != 1) begin
      tests_failed++; $display("[TB] FAIL enc_start: got %0d pulses last at cycle %0d, expected 1 at cycle 1", start_cnt, start_cyc);
    end
    tests_run++;
    if (issue_data !== FIPS_PT) begin tests_failed++; $display("[TB] FAIL enc_core_data: got %h, expected %h", issue_data, FIPS_PT); end
    tests_run++;
    if (rsp_cyc != 42) begin tests_failed++; $display("[TB] FAIL enc_latency: got cycle %0d, expected 42", rsp_cyc); end
    tests_run++;
    if (saw1 !== 1'b0) begin tests_failed++; $display("[TB] FAIL enc_rsp1_quiet: got %0b, expected 0", saw1); end
    e = sb.pop_front();
    tests_run++;
    if ({bus.rsp1_valid, bus.rsp_err, bus.rsp_data} !== e) begin
      tests_failed++; $display("[TB] FAIL enc_result: got %h, expected %h", {bus.rsp1_valid, bus.rsp_err, bus.rsp_data}, e);
    end
    take_rsp(1'b0);
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.rsp0_valid} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL enc_release: got %b, expected 00", {bus.busy, bus.rsp0_valid});
    end
  endtask

  task automatic test_round_robin();
    bit mdl_last, exp_port, got, ok, p;
    int cyc;
    logic [DATA_W-1:0] d [2];
    logic [DATA_W-1:0] k [2];
    exp_t e;
    core_lat = 4;
    pulse_reset();
    mdl_last = 1'b1;
    for (int i = 0; i < 2; i++) begin d[i] = rnd128(); k[i] = rnd128(); end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_data = d[0]; bus.req0_key = k[0]; bus.req0_dec = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = d[1]; bus.req1_key = k[1]; bus.req1_dec = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_port = !mdl_last;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (bus.req0_ready === 1'b1 || bus.req1_ready === 1'b1) begin got = 1'b1; break; end
        @(negedge clk);
      end
      tests_run++;
      if ({bus.req1_ready, bus.req0_ready} !== (exp_port ? 2'b10 : 2'b01)) begin
        tests_failed++; $display("[TB] FAIL rr_grant%0d: got %b, expected %b", j, {bus.req1_ready, bus.req0_ready}, exp_port ? 2'b10 : 2'b01);
      end
      sb.push_back('{port: exp_port, err: 1'b0, data: core_fn(d[exp_port], k[exp_port], exp_port)});
      @(posedge clk);
      #1;
      d[exp_port] = rnd128();
      if (exp_port) bus.req1_data = d[1];
      else          bus.req0_data = d[0];
      wait_rsp(50, cyc, p, ok);
      tests_run++;
      if (ok !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_rsp%0d_timeout: got %0b, expected 1", j, ok); end
      e = sb.pop_front();
      tests_run++;
      if ({p, bus.rsp_err, bus.rsp_data} !== e) begin
        tests_failed++; $display("[TB] FAIL rr_result%0d: got %h, expected %h", j, {p, bus.rsp_err, bus.rsp_data}, e);
      end
      if (got) take_rsp(p);
      mdl_last = exp_port;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_hold_rsp();
    bit ok, p;
    int cyc, bad;
    logic [DATA_W-1:0] d, k, d2, k2, held;
    exp_t e;
    core_lat = 6;
    d = rnd128(); k = rnd128(); d2 = rnd128(); k2 = rnd128();
    accept(1'b1, d, k, 1'b1, ok);
    sb.push_back('{port: 1'b1, err: 1'b0, data: core_fn(d, k, 1'b1)});
    wait_rsp(40, cyc, p, ok);
    tests_run++;
    if ({ok, p} !== 2'b11) begin tests_failed++; $display("[TB] FAIL hold_rsp_seen: got %b, expected 11", {ok, p}); end
    held = bus.rsp_data;
    bus.req0_valid = 1'b1; bus.req0_data = d2; bus.req0_key = k2; bus.req0_dec = 1'b0;
    bus.rsp0_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.rsp1_valid !== 1'b1 || bus.rsp_data !== held || bus.req0_ready !== 1'b0 || bus.rsp0_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("[TB] FAIL hold_stable: got %0d bad cycles, expected 0", bad); end
    bus.rsp0_ready = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if ({p, bus.rsp_err, bus.rsp_data} !== e) begin
      tests_failed++; $display("[TB] FAIL hold_result: got %h, expected %h", {p, bus.rsp_err, bus.rsp_data}, e);
    end
    take_rsp(1'b1);
    tests_run++;
    if (bus.req0_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_turnaround: got %0b, expected 1", bus.req0_ready); end
    sb.push_back('{port: 1'b0, err: 1'b0, data: core_fn(d2, k2, 1'b0)});
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    wait_rsp(40, cyc, p, ok);
    e = sb.pop_front();
    tests_run++;
    if ({ok, p, bus.rsp_err, bus.rsp_data} !== {1'b1, e}) begin
      tests_failed++; $display("[TB] FAIL hold_next_job: got %h, expected %h", {ok, p, bus.rsp_err, bus.rsp_data}, {1'b1, e});
    end
    if (ok) take_rsp(p);
  endtask

  task automatic test_spurious_done();
    bit ok, p;
    int cyc;
    logic [DATA_W-1:0] d, k;
    exp_t e;
    core_lat = 8;
    d = rnd128(); k = rnd128();
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL spur_idle: got %b, expected 000", {bus.busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    accept(1'b0, d, k, 1'b1, ok);
    sb.push_back('{port: 1'b0, err: 1'b0, data: core_fn(d, k, 1'b1)});
    inj_done = 1'b1;
    @(posedge clk);
    #1;
    inj_done = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b100) begin
      tests_failed++; $display("[TB] FAIL spur_issue: got %b, expected 100", {bus.busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    wait_rsp(40, cyc, p, ok);
    e = sb.pop_front();
    tests_run++;
    if ({ok, p, bus.rsp_err, bus.rsp_data} !== {1'b1, e}) begin
      tests_failed++; $display("[TB] FAIL spur_real_done: got %h, expected %h", {ok, p, bus.rsp_err, bus.rsp_data}, {1'b1, e});
    end
    if (ok) take_rsp(p);
  endtask

  task automatic test_reset_mid_job();
    bit ok, p;
    int cyc;
    logic [DATA_W-1:0] d, k;
    logic [4:0] scal;
    exp_t e;
    core_lat = 30;
    d = rnd128(); k = rnd128();
    accept(1'b0, d, k, 1'b1, ok);
    repeat (5) @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_busy: got %0b, expected 1", bus.busy); end
    reset = 1'b0;
    #1;
    scal = {bus.busy, bus.core_start, bus.core_dec, bus.rsp0_valid, bus.rsp1_valid};
    tests_run++;
    if (scal !== 5'b00000 || (bus.core_data | bus.core_key | bus.rsp_data) !== '0) begin
      tests_failed++; $display("[TB] FAIL rst_mid_outputs: got %b data %h, expected 00000 and 0", scal, bus.core_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    d = rnd128(); k = rnd128();
    bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_key = k; bus.req1_dec = 1'b0;
    #1;
    tests_run++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
      tests_failed++; $display("[TB] FAIL rst_mid_grant: got %b, expected 10", {bus.req1_ready, bus.req0_ready});
    end
    sb.push_back('{port: 1'b1, err: 1'b0, data: core_fn(d, k, 1'b0)});
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    wait_rsp(60, cyc, p, ok);
    e = sb.pop_front();
    tests_run++;
    if ({ok, p, bus.rsp_err, bus.rsp_data} !== {1'b1, e}) begin
      tests_failed++; $display("[TB] FAIL rst_mid_job: got %h, expected %h", {ok, p, bus.rsp_err, bus.rsp_data}, {1'b1, e});
    end
    if (ok) take_rsp(p);
  endtask

`ifdef AES_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, p;
    int cyc;
    logic [DATA_W-1:0] d, k;
    exp_t e;
    d = rnd128(); k = rnd128();
    core_auto = 1'b0;
    accept(1'b1, d, k, 1'b0, ok);
    sb.push_back('{port: 1'b1, err: 1'b1, data: '0});
    wait_rsp(100, cyc, p, ok);
    tests_run++;
    if (cyc != 65) begin tests_failed++; $display("[TB] FAIL to_latency: got cycle %0d, expected 65", cyc); end
    e = sb.pop_front();
    tests_run++;
    if ({p, bus.rsp_err, bus.rsp_data} !== e) begin
      tests_failed++; $display("[TB] FAIL to_result: got %h, expected %h", {p, bus.rsp_err, bus.rsp_data}, e);
    end
    if (ok) take_rsp(p);
    core_auto = 1'b1;
    core_lat = 63;
    accept(1'b0, d, k, 1'b0, ok);
    sb.push_back('{port: 1'b0, err: 1'b0, data: core_fn(d, k, 1'b0)});
    wait_rsp(100, cyc, p, ok);
    tests_run++;
    if (cyc != 65) begin tests_failed++; $display("[TB] FAIL to_tie_latency: got cycle %0d, expected 65", cyc); end
    e = sb.pop_front();
    tests_run++;
    if ({p, bus.rsp_err, bus.rsp_data} !== e) begin
      tests_failed++; $display("[TB] FAIL to_tie_result: got %h, expected %h", {p, bus.rsp_err, bus.rsp_data}, e);
    end
    if (ok) take_rsp(p);
  endtask
`else
  task automatic test_no_timeout();
    bit ok, p;
    int cyc;
    logic [DATA_W-1:0] d, k;
    exp_t e;
    d = rnd128(); k = rnd128();
    core_lat = 80;
    accept(1'b1, d, k, 1'b1, ok);
    sb.push_back('{port: 1'b1, err: 1'b0, data: core_fn(d, k, 1'b1)});
    wait_rsp(120, cyc, p, ok);
    tests_run++;
    if (cyc != 82) begin tests_failed++; $display("[TB] FAIL slow_latency: got cycle %0d, expected 82", cyc); end
    e = sb.pop_front();
    tests_run++;
    if ({p, bus.rsp_err, bus.rsp_data} !== e) begin
      tests_failed++; $display("[TB] FAIL slow_result: got %h, expected %h", {p, bus.rsp_err, bus.rsp_data}, e);
    end
    if (ok) take_rsp(p);
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_round_robin();
    test_hold_rsp();
    test_spurious_done();
    test_reset_mid_job();
`ifdef AES_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/aes_engine_arbiter.md
# aes_engine_arbiter

Shares one AES cipher core (encrypt or inverse-cipher round engine with start/done control) between two client ports. Accepts a 128-bit block, 128-bit key and direction bit from either client over a valid/ready handshake, round-robin between them, launches the core with a one-cycle start pulse and returns the result to the granted client over a response handshake. Sits between the system-side clients and the cipher core controller, one job in flight at a time.

## Interface
- `DATA_W`, 128: block and key width.
- `TIMEOUT`, 63: core watchdog limit in cycles. Used only with `AES_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  client job request.
- `req0_ready` / `req1_ready`  out  1  job accepted on the cycle where valid&ready.
- `req0_data` / `req1_data`  in  DATA_W  input block.
- `req0_key` / `req1_key`  in  DATA_W  cipher key.
- `req0_dec` / `req1_dec`  in  1  1 = decrypt, 0 = encrypt.
- `rsp0_valid` / `rsp1_valid`  out  1  result available.
- `rsp0_ready` / `rsp1_ready`  in  1  client takes the result.
- `rsp_data`  out  DATA_W  result block, shared by both ports; meaningful only with rspN_valid.
- `rsp_err`  out  1  result is a timeout abort; meaningful only with rspN_valid.
- `core_start`  out  1  one-cycle launch pulse.
- `core_dec`  out  1  latched direction.
- `core_data`  out  DATA_W  latched block.
- `core_key`  out  DATA_W  latched key.
- `core_result`  in  DATA_W  core output.
- `core_done`  in  1  core finished, single-cycle pulse.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant selection is combinational. If exactly one reqN_valid is high, that port is selected. If both are high, the port other than `last_grant` is selected.
  - Only the selected port's reqN_ready is high.
  - On the handshake, latch data, key and dec into the core_* registers, record the granted port, and go to ISSUE.
- **ISSUE**
  - core_start = 1 for exactly this cycle.
  - core_done is ignored in this state.
  - Go to WAIT.
- **WAIT**
  - When core_done = 1, capture core_result into rsp_data, clear rsp_err and go to RESP.
- **RESP**
  - rspN_valid is high for the granted port only. rsp_data and rsp_err are held stable.
  - When rspN_ready = 1, set `last_grant` to the granted port, drop rspN_valid and go to IDLE.
  - The other port's rsp_ready is ignored.
- core_data, core_key and core_dec stay stable from ISSUE until the next acceptance.
- In every state except IDLE, both req_ready outputs are 0. Requests wait; they are not dropped.
- A core_done pulse arriving in IDLE, ISSUE or RESP is ignored.
- Reset mid-job: the state returns to IDLE and the pending job is lost. No response is issued.
- Reset values:
  - state IDLE, `last_grant` = 1, so port 0 wins the first tie.
  - All ready and valid outputs 0; core_start 0; core_dec 0; core_data, core_key and rsp_data 0; rsp_err 0; busy 0.

## Timing
- Request accepted at clock edge T0. ISSUE runs in cycle T0+1 and core_start is high during it.
- If core_done is sampled high in cycle Tk, rspN_valid rises in cycle Tk+1.
- Best-case turnaround is 1 cycle from rspN_ready to the next req_ready, because the first cycle back in IDLE can already accept.
- All outputs are registered, except req_ready, which is combinational from the req_valid inputs, the state and `last_grant`.

## Configuration
- `AES_ARB_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without core_done, go to RESP with rsp_data = 0 and rsp_err = 1.
  - core_done in the same cycle as the timeout wins: normal result, rsp_err = 0.
- Undefined:
  - No counter is built and WAIT lasts indefinitely.
  - rsp_err is constant 0.

## Test plan
- Encrypt on port 0: FIPS-197 key 000102..0f, data 00112233..ff, dec = 0; core model done after 40 cycles. Expect core_start high in T0+1 only, rsp0_valid in cycle 42, rsp_data = 69c4e0d8..c55a, rsp1_valid = 0.
- Simultaneous req0/req1 from reset: port 0 served first. With both requests held, the next grant goes to port 1, then port 0 again (alternation over 4 jobs).
- Hold rsp1_ready low for 10 cycles: rsp1_valid and rsp_data stay stable, and req0_ready stays 0 throughout.
- Spurious core_done in IDLE and ISSUE: no state change and no response. The real done in WAIT produces the response.
- With `AES_ARB_TIMEOUT_EN` and TIMEOUT = 63, core never done: 63 cycles in WAIT, then rsp_err = 1 and rsp_data = 0. With done and timeout in the same cycle: rsp_err = 0.
- Reset asserted in WAIT: all outputs take their reset values immediately. After release, an idle port-1 request is granted at once.
